// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared hazard-controller state encoding and PC mux selects
package pipe_ctrl_pkg;

  // Hazard controller FSM states
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    TRAP_HOLD = 2'b01,
    MRET_HOLD = 2'b10
  } hz_state_e;

  // PC mux selects, also decoded by the PC mux in Fetch
  localparam logic [1:0] PC_SEL_PC4    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_MTVEC  = 2'b10;
  localparam logic [1:0] PC_SEL_MEPC   = 2'b11;

  // True when a writing instruction's destination matches a consumer source.
  // x0 never matches because its value is hard-wired.
  function automatic logic reg_match(input logic       wr_en,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return wr_en && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// rtl/pipe_fwd_unit.sv - MemWriteback-to-Execute operand forwarding comparators
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_MW,
  input  logic       reg_wr_MW,
  output logic       fwd_a,
  output logic       fwd_b
);

  // Purely combinational so forwarding stays correct in every FSM state
  always_comb begin
    fwd_a = reg_match(reg_wr_MW, rd_MW, rs1_E);
    fwd_b = reg_match(reg_wr_MW, rd_MW, rs2_E);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/PC-select control with trap and mret holds
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             rd_en_E,
  input  logic [4:0]       rd_MW,
  input  logic             reg_wr_MW,
  input  logic             br_taken_E,
  input  logic             irq_pending,
  input  logic             is_mret_MW,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [1:0]       pc_sel,
  output logic             trap_take,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  pipe_fwd_unit u_fwd (
    .rs1_E     (rs1_E),
    .rs2_E     (rs2_E),
    .rd_MW     (rd_MW),
    .reg_wr_MW (reg_wr_MW),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );

  // Load in Execute feeding a source of the instruction in Decode
  always_comb begin
    load_use = reg_match(rd_en_E, rd_E, rs1_D) || reg_match(rd_en_E, rd_E, rs2_D);
  end

  // Next state and control outputs; one action per cycle, mret > branch > irq > load-use
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    pc_sel      = PC_SEL_PC4;
    trap_take   = 1'b0;
    if (reset) begin
      // Reset overrides everything, including an in-progress hold
      state_d     = RUN;
      stall_cnt_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (is_mret_MW) begin
            pc_sel  = PC_SEL_MEPC;
            flush_D = 1'b1;
            flush_E = 1'b1;
            state_d = MRET_HOLD;
          end else if (br_taken_E) begin
            pc_sel  = PC_SEL_BRANCH;
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (irq_pending) begin
            trap_take = 1'b1;
            pc_sel    = PC_SEL_MTVEC;
            flush_D   = 1'b1;
            flush_E   = 1'b1;
            state_d   = TRAP_HOLD;
          end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
            if (stall_cnt_q != CNT_MAX) begin
              stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
          end
        end
        TRAP_HOLD, MRET_HOLD: begin
          // Instructions behind the redirect are squashed; their hazards do not count
          flush_D = 1'b1;
          flush_E = 1'b1;
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and stall counter registers
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with CNT_W=2
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_MW;
  logic       rd_en_E, reg_wr_MW, br_taken_E, irq_pending, is_mret_MW;
  logic       stall_F, stall_D, flush_D, flush_E, fwd_a, fwd_b, trap_take;
  logic [1:0] pc_sel;
  logic [1:0] stall_cnt;

  typedef struct {
    string      name;
    logic       s_f, s_d, f_d, f_e, fa, fb, tt;
    logic [1:0] pc;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pipe_hazard_ctrl #(.CNT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_D       (rs1_D),
    .rs2_D       (rs2_D),
    .rs1_E       (rs1_E),
    .rs2_E       (rs2_E),
    .rd_E        (rd_E),
    .rd_en_E     (rd_en_E),
    .rd_MW       (rd_MW),
    .reg_wr_MW   (reg_wr_MW),
    .br_taken_E  (br_taken_E),
    .irq_pending (irq_pending),
    .is_mret_MW  (is_mret_MW),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .flush_E     (flush_E),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .pc_sel      (pc_sel),
    .trap_take   (trap_take),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, exp);
  endtask

  // Monitor: every cycle is an output sample; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "stall_F",   {3'b0, stall_F},   {3'b0, e.s_f});
        chk(e.name, "stall_D",   {3'b0, stall_D},   {3'b0, e.s_d});
        chk(e.name, "flush_D",   {3'b0, flush_D},   {3'b0, e.f_d});
        chk(e.name, "flush_E",   {3'b0, flush_E},   {3'b0, e.f_e});
        chk(e.name, "fwd_a",     {3'b0, fwd_a},     {3'b0, e.fa});
        chk(e.name, "fwd_b",     {3'b0, fwd_b},     {3'b0, e.fb});
        chk(e.name, "trap_take", {3'b0, trap_take}, {3'b0, e.tt});
        chk(e.name, "pc_sel",    {2'b0, pc_sel},    {2'b0, e.pc});
        chk(e.name, "stall_cnt", {2'b0, stall_cnt}, {2'b0, e.cnt});
      end
    end
  end

  // Queue the expected response for the inputs currently applied, then advance one cycle
  task automatic cyc(input string nm, input logic sf, input logic sd, input logic fd, input logic fe,
                     input logic fa, input logic fb, input logic tt, input logic [1:0] pc,
                     input logic [1:0] cnt);
    exp_t e;
    e.name = nm; e.s_f = sf; e.s_d = sd; e.f_d = fd; e.f_e = fe;
    e.fa = fa; e.fb = fb; e.tt = tt; e.pc = pc; e.cnt = cnt;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_MW = 0;
    rd_en_E = 0; reg_wr_MW = 0; br_taken_E = 0; irq_pending = 0; is_mret_MW = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // Reset overrides every request
    irq_pending = 1; br_taken_E = 1; is_mret_MW = 1; rd_en_E = 1; rd_E = 5; rs1_D = 5;
    cyc("reset_override", 0,0,0,0, 0,0,0, 2'b00, 2'd0);
    reset = 1'b0; idle();
    cyc("reset_state",    0,0,0,0, 0,0,0, 2'b00, 2'd0);
    // Load-use stall
    rd_en_E = 1; rd_E = 5; rs2_D = 5;
    cyc("load_use",       1,1,0,1, 0,0,0, 2'b00, 2'd0);
    idle();
    cyc("after_lu",       0,0,0,0, 0,0,0, 2'b00, 2'd1);
    rd_en_E = 1; rd_E = 0; rs1_D = 0;
    cyc("lu_x0",          0,0,0,0, 0,0,0, 2'b00, 2'd1);
    idle(); br_taken_E = 1; rd_en_E = 1; rd_E = 5; rs1_D = 5;
    cyc("br_over_lu",     0,0,1,1, 0,0,0, 2'b01, 2'd1);
    idle();
    cyc("no_cnt_on_br",   0,0,0,0, 0,0,0, 2'b00, 2'd1);
    // Forwarding
    reg_wr_MW = 1; rd_MW = 7; rs1_E = 7; rs2_E = 7;
    cyc("fwd_both",       0,0,0,0, 1,1,0, 2'b00, 2'd1);
    rd_MW = 0; rs1_E = 0; rs2_E = 0;
    cyc("fwd_x0",         0,0,0,0, 0,0,0, 2'b00, 2'd1);
    rd_MW = 7; rs1_E = 7; rs2_E = 3;
    cyc("fwd_a_only",     0,0,0,0, 1,0,0, 2'b00, 2'd1);
    reg_wr_MW = 0; rs2_E = 7;
    cyc("fwd_no_wr",      0,0,0,0, 0,0,0, 2'b00, 2'd1);
    // Irq lost to branch, taken next cycle, then trap hold suppresses branch/load-use
    idle(); irq_pending = 1; br_taken_E = 1;
    cyc("irq_lost_br",    0,0,1,1, 0,0,0, 2'b01, 2'd1);
    br_taken_E = 0;
    cyc("irq_deferred",   0,0,1,1, 0,0,1, 2'b10, 2'd1);
    br_taken_E = 1; rd_en_E = 1; rd_E = 5; rs1_D = 5; reg_wr_MW = 1; rd_MW = 7; rs1_E = 7;
    cyc("trap_hold",      0,0,1,1, 1,0,0, 2'b00, 2'd1);
    idle();
    cyc("hold_exit",      0,0,0,0, 0,0,0, 2'b00, 2'd1);
    // mret with pending irq
    is_mret_MW = 1; irq_pending = 1;
    cyc("mret",           0,0,1,1, 0,0,0, 2'b11, 2'd1);
    is_mret_MW = 0;
    cyc("mret_hold",      0,0,1,1, 0,0,0, 2'b00, 2'd1);
    cyc("irq_after_mret", 0,0,1,1, 0,0,1, 2'b10, 2'd1);
    irq_pending = 0;
    cyc("trap_hold2",     0,0,1,1, 0,0,0, 2'b00, 2'd1);
    idle();
    cyc("idle2",          0,0,0,0, 0,0,0, 2'b00, 2'd1);
    // Counter saturation at 3
    rd_en_E = 1; rd_E = 3; rs1_D = 3;
    for (int i = 0; i < 5; i++) begin
      cyc("lu_sat",       1,1,0,1, 0,0,0, 2'b00, (i >= 2) ? 2'd3 : 2'(i + 1));
    end
    idle();
    cyc("sat_hold",       0,0,0,0, 0,0,0, 2'b00, 2'd3);
    // Reset in the middle of a trap hold
    irq_pending = 1;
    cyc("irq_take",       0,0,1,1, 0,0,1, 2'b10, 2'd3);
    reset = 1'b1;
    cyc("reset_in_hold",  0,0,0,0, 0,0,0, 2'b00, 2'd3);
    reset = 1'b0; irq_pending = 0;
    cyc("post_reset",     0,0,0,0, 0,0,0, 2'b00, 2'd0);
    irq_pending = 1;
    cyc("irq_post_reset", 0,0,1,1, 0,0,1, 2'b10, 2'd0);
    irq_pending = 0;
    cyc("hold3",          0,0,1,1, 0,0,0, 2'b00, 2'd0);
    idle();
    chk("scoreboard", "drained", 4'(exp_q.size()), 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the stall-cycle performance counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 rs1_D, rs2_D  input  5  source registers of the instruction in Decode.
REQ-005 rs1_E, rs2_E  input  5  source registers of the instruction in Execute.
REQ-006 rd_E  input  5; rd_en_E  input  1  destination register and memory-read flag of the instruction in Execute.
REQ-007 rd_MW  input  5; reg_wr_MW  input  1  destination register and write enable in MemWriteback.
REQ-008 br_taken_E  input  1  branch or jump resolved taken in Execute.
REQ-009 irq_pending  input  1  level interrupt request from the CSR file, already masked by mie/mstatus.
REQ-010 is_mret_MW  input  1  mret in MemWriteback.
REQ-011 stall_F, stall_D  output  1  hold the PC and Fetch/Decode registers.
REQ-012 flush_D, flush_E  output  1  bubble the Fetch/Decode and Decode/Execute registers.
REQ-013 fwd_a, fwd_b  output  1  select the MW writeback value for Execute operand A/B.
REQ-014 pc_sel  output  2  00 pc+4, 01 branch target, 10 mtvec, 11 mepc.
REQ-015 trap_take  output  1  single-cycle pulse instructing the CSR file to save mepc/mcause.
REQ-016 stall_cnt  output  CNT_W  count of load-use stall cycles.

Function
REQ-017 FSM states: RUN, TRAP_HOLD, MRET_HOLD; reset state RUN.
REQ-018 Forwarding is combinational in every state: fwd_a = reg_wr_MW && rd_MW!=0 && rd_MW==rs1_E; fwd_b is identical with rs2_E.
REQ-019 Load-use hazard: rd_en_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D).
REQ-020 RUN priority is mret > branch > irq > load-use; exactly one action is taken per cycle.
REQ-021 RUN with is_mret_MW: pc_sel=11, flush_D=flush_E=1, next state MRET_HOLD.
REQ-022 RUN with br_taken_E (no mret): pc_sel=01, flush_D=flush_E=1, state stays RUN.
REQ-023 RUN with irq_pending (no mret, no branch): trap_take=1, pc_sel=10, flush_D=flush_E=1, next state TRAP_HOLD.
REQ-024 RUN with load-use only: stall_F=stall_D=1, flush_E=1, pc_sel=00, stall_cnt increments.
REQ-025 TRAP_HOLD and MRET_HOLD: flush_D=1, flush_E=1, pc_sel=00, irq_pending ignored, next state RUN after exactly one cycle.
REQ-026 In HOLD states, a branch or load-use is suppressed because its instruction is being flushed.
REQ-027 A deferred irq (lost to a branch or mret) is taken in the first RUN cycle in which it is still asserted; the input is level-sensitive, so no latch is kept.
REQ-028 stall_cnt saturates at 2^CNT_W-1 and does not wrap.
REQ-029 trap_take is asserted in no state other than the RUN irq case, and never for two consecutive cycles.
REQ-030 Outputs other than fwd_a/fwd_b are combinational from state plus inputs; stall_cnt is registered.

Reset
REQ-031 reset forces state=RUN and stall_cnt=0 on the next edge, overriding every input; during the reset cycle stall/flush/trap_take=0 and pc_sel=00.
REQ-032 A reset asserted in TRAP_HOLD or MRET_HOLD abandons the hold with no residual flush.

Structure
REQ-033 pipe_ctrl_pkg holds the state enum and the PC_SEL_* 2-bit constants, shared with the PC mux.
REQ-034 The forwarding comparators are a sub-module, pipe_fwd_unit; the FSM and counter stay in the top level.

Verification
REQ-035 Load-use: rd_en_E=1, rd_E=5, rs2_D=5 -> stall_F=stall_D=flush_E=1 for one cycle; stall_cnt 0->1.
REQ-036 Load-use with rd_E=0 and rs1_D=0 -> no stall; branch together with load-use -> pc_sel=01, stall_F=0.
REQ-037 irq_pending together with br_taken_E -> pc_sel=01, trap_take=0; next cycle pc_sel=10, trap_take=1; following cycle TRAP_HOLD with flush_D=1 and trap_take=0.
REQ-038 is_mret_MW with irq_pending -> pc_sel=11, then one MRET_HOLD cycle, then the irq is taken.
REQ-039 Forward: reg_wr_MW=1, rd_MW=7, rs1_E=7, rs2_E=7 -> fwd_a=fwd_b=1; with rd_MW=0 -> both 0.
REQ-040 CNT_W=2 with 5 load-use cycles -> stall_cnt=3 (saturated); reset asserted mid-TRAP_HOLD -> RUN and stall_cnt=0.
